// File: rtl/cp0_exc_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cp0_exc_ctrl_if                                                            |
// | M-stage pipeline <-> CP0 exception controller signal bundle                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface cp0_exc_ctrl_if;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic        bd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [4:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  modport master (
    output we, addr, wdata, pc, bd, exc_valid, exc_code, hw_int, eret,
    input  rdata, req, epc_out, handler_pc
  );

  modport slave (
    input  we, addr, wdata, pc, bd, exc_valid, exc_code, hw_int, eret,
    output rdata, req, epc_out, handler_pc
  );
endinterface
`default_nettype wire

// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cp0_exc_ctrl                                                               |
// | CP0 exception/interrupt controller: SR/Cause/EPC/Count/Compare/PRId        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID       = 32'h0000_2021,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input logic           clk,
  input logic           reset,
  cp0_exc_ctrl_if.slave bus
);

  localparam logic [4:0] c_reg_count   = 5'd9;
  localparam logic [4:0] c_reg_compare = 5'd11;
  localparam logic [4:0] c_reg_sr      = 5'd12;
  localparam logic [4:0] c_reg_cause   = 5'd13;
  localparam logic [4:0] c_reg_epc     = 5'd14;
  localparam logic [4:0] c_reg_prid    = 5'd15;

  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [4:0]  r_cause_hw;
  logic        r_timer_ip;
  logic [4:0]  r_cause_exc;
  logic [31:2] r_epc;
  logic [31:0] r_count;
  logic [31:0] r_compare;

  logic [5:0]  w_ip_next;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [31:0] w_count_inc;
  logic [31:0] w_pc_aligned;
  logic [31:0] w_epc_new;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  // Interrupt arbitration uses live hw_int, not the registered IP copy.
  assign w_ip_next    = {r_timer_ip, bus.hw_int};
  assign w_int_req    = r_sr_ie & ~r_sr_exl & (|(w_ip_next & r_sr_im));
  assign w_exc_req    = bus.exc_valid & ~r_sr_exl;
  assign w_req        = reset & (w_int_req | w_exc_req);
  assign w_count_inc  = r_count + 32'd1;
  assign w_pc_aligned = bus.pc & 32'hFFFF_FFFC;
  assign w_epc_new    = bus.bd ? (w_pc_aligned - 32'd4) : w_pc_aligned;

  assign w_sr    = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
  assign w_cause = {r_cause_bd, 15'd0, r_timer_ip, r_cause_hw, 3'd0, r_cause_exc, 2'd0};

  assign bus.req        = w_req;
  assign bus.epc_out    = reset ? {r_epc, 2'b00} : 32'd0;
  assign bus.handler_pc = HANDLER_PC;

  always_comb begin
    bus.rdata = 32'd0;
    if (bus.addr == c_reg_prid) begin
      bus.rdata = PRID;
    end else if (reset) begin
      case (bus.addr)
        c_reg_count:   bus.rdata = r_count;
        c_reg_compare: bus.rdata = r_compare;
        c_reg_sr:      bus.rdata = w_sr;
        c_reg_cause:   bus.rdata = w_cause;
        c_reg_epc:     bus.rdata = {r_epc, 2'b00};
        default:       bus.rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sr_im     <= 6'd0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_hw  <= 5'd0;
      r_timer_ip  <= 1'b0;
      r_cause_exc <= 5'd0;
      r_epc       <= 30'd0;
      r_count     <= 32'd0;
      r_compare   <= 32'd0;
    end else begin
      r_count    <= w_count_inc;
      r_cause_hw <= bus.hw_int;
      if ((w_count_inc == r_compare) && (r_compare != 32'd0)) begin
        r_timer_ip <= 1'b1;
      end
      // A taken exception swallows any eret/mtc0 issued in the same cycle.
      if (w_req) begin
        r_sr_exl    <= 1'b1;
        r_cause_exc <= w_int_req ? 5'd0 : bus.exc_code;
        r_cause_bd  <= bus.bd;
        r_epc       <= w_epc_new[31:2];
      end else if (bus.eret) begin
        r_sr_exl <= 1'b0;
      end else if (bus.we) begin
        case (bus.addr)
          c_reg_count: r_count <= bus.wdata;
          c_reg_compare: begin
            r_compare  <= bus.wdata;
            r_timer_ip <= 1'b0;
          end
          c_reg_sr: begin
            r_sr_im  <= bus.wdata[15:10];
            r_sr_exl <= bus.wdata[1];
            r_sr_ie  <= bus.wdata[0];
          end
          c_reg_epc: r_epc <= bus.wdata[31:2];
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
